// File: rtl/div_pkg.sv
// Shared types and defaults for the shared-divider controller.
//   div_state_e    : controller FSM states
//   DIV_N_DEFAULT  : default operand/result width
//   DIV_MC_DEFAULT : default multicycle hold length
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } div_state_e;

  localparam int unsigned DIV_N_DEFAULT  = 32;
  localparam int unsigned DIV_MC_DEFAULT = 4;

endpackage

// File: rtl/div_share_ctrl_if.sv
// Request/response bundle between the requesters and div_share_ctrl.
//   req_valid/req_ready          : per-requester handshake (NREQ bits)
//   req_dividend/req_divisor     : per-requester signed operands (NREQ x N)
//   rsp_valid/rsp_ready          : response handshake
//   rsp_id/rsp_quotient/
//   rsp_remainder/rsp_div_by_zero: response payload
//   busy                         : controller not idle
// master = requester/consumer side, slave = controller side.
interface div_share_ctrl_if
  import div_pkg::*;
#(
  parameter int unsigned N    = DIV_N_DEFAULT,
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0][N-1:0] req_dividend;
  logic [NREQ-1:0][N-1:0] req_divisor;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [IDW-1:0]         rsp_id;
  logic [N-1:0]           rsp_quotient;
  logic [N-1:0]           rsp_remainder;
  logic                   rsp_div_by_zero;
  logic                   busy;

  modport master (
    output req_valid, req_dividend, req_divisor, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder,
           rsp_div_by_zero, busy
  );

  modport slave (
    input  req_valid, req_dividend, req_divisor, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder,
           rsp_div_by_zero, busy
  );

endinterface

// File: rtl/integer_divider.sv
// Combinational signed divider, truncating toward zero.
//   dividend, divisor : two's complement operands
//   quotient          : dividend / divisor
//   remainder         : sign follows the dividend
// Dividend 0 gives 0/0; divisor 0 with nonzero dividend gives all-ones
// for both outputs; most-negative / -1 wraps to most-negative, rem 0.
module integer_divider #(
  parameter int unsigned n = 32
) (
  input  logic [n-1:0] dividend,
  input  logic [n-1:0] divisor,
  output logic [n-1:0] quotient,
  output logic [n-1:0] remainder
);

  logic         a_neg;
  logic         b_neg;
  logic [n-1:0] a_mag;
  logic [n-1:0] b_mag;
  logic [n-1:0] q_mag;
  logic [n-1:0] r_mag;

  // Magnitudes are unsigned n-bit, so the most-negative value maps to
  // 2^(n-1) exactly and the wrap case falls out of the sign fix-up.
  always_comb begin
    a_neg     = dividend[n-1];
    b_neg     = divisor[n-1];
    a_mag     = a_neg ? -dividend : dividend;
    b_mag     = b_neg ? -divisor : divisor;
    q_mag     = '0;
    r_mag     = '0;
    quotient  = '0;
    remainder = '0;
    if (divisor != '0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    if (dividend == '0) begin
      quotient  = '0;
      remainder = '0;
    end else if (divisor == '0) begin
      quotient  = '1;
      remainder = '1;
    end else begin
      quotient  = (a_neg ^ b_neg) ? -q_mag : q_mag;
      remainder = a_neg ? -r_mag : r_mag;
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   : request vector
//   ptr   : highest-priority index this cycle
//   en    : grant enable
//   grant : one-hot grant (all zero when disabled or no request)
//   idx   : encoded index of the grant
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  logic           found;
  logic [IDW-1:0] cand;

  // Scan from ptr upward, wrapping; first asserted request wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IDW'((32'(ptr) + i) % NREQ);
      if (en && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one combinational integer_divider between NREQ requesters.
// One request is accepted at a time (round-robin), its operands are held
// in registers for MC_CYCLES clocks, then the result is captured into a
// response register tagged with the requester index.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : request/response bundle (slave side)
module div_share_ctrl
  import div_pkg::*;
#(
  parameter int unsigned N         = DIV_N_DEFAULT,
  parameter int unsigned NREQ      = 4,
  parameter int unsigned MC_CYCLES = DIV_MC_DEFAULT,
  parameter int unsigned IDW       = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  div_share_ctrl_if.slave  bus
);

  localparam int unsigned CW = $clog2(MC_CYCLES + 1);

  div_state_e     state_q;
  div_state_e     state_d;

  logic [IDW-1:0] rr_ptr;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0] grant_idx;
  logic           accept;
  logic           capture;

  // Operand registers: only written on an acceptance edge, which is what
  // makes the divider a legal MC_CYCLES multicycle path.
  logic [N-1:0]   op_a;
  logic [N-1:0]   op_b;
  logic [IDW-1:0] op_id;
  logic [CW-1:0]  cnt;

  logic [N-1:0]   div_q;
  logic [N-1:0]   div_r;
  logic           dbz;

  logic [IDW-1:0] rsp_id_q;
  logic [N-1:0]   rsp_q_q;
  logic [N-1:0]   rsp_r_q;
  logic           rsp_dbz_q;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .en    (state_q == IDLE),
    .grant (grant),
    .idx   (grant_idx)
  );

  integer_divider #(
    .n (N)
  ) u_div (
    .dividend  (op_a),
    .divisor   (op_b),
    .quotient  (div_q),
    .remainder (div_r)
  );

  assign dbz     = (op_b == '0) && (op_a != '0);
  assign accept  = (state_q == IDLE) && (grant != '0);
  assign capture = (state_q == CALC) && (cnt == CW'(1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)        state_d = CALC;
      CALC:    if (capture)       state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      op_a   <= '0;
      op_b   <= '0;
      op_id  <= '0;
      cnt    <= '0;
    end else if (accept) begin
      op_a   <= bus.req_dividend[grant_idx];
      op_b   <= bus.req_divisor[grant_idx];
      op_id  <= grant_idx;
      cnt    <= CW'(MC_CYCLES);
      rr_ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
    end else if (state_q == CALC) begin
      cnt    <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id_q  <= '0;
      rsp_q_q   <= '0;
      rsp_r_q   <= '0;
      rsp_dbz_q <= 1'b0;
    end else if (capture) begin
      rsp_id_q  <= op_id;
      rsp_q_q   <= div_q;
      rsp_r_q   <= div_r;
      rsp_dbz_q <= dbz;
    end
  end

  assign bus.req_ready       = grant;
  assign bus.rsp_valid       = (state_q == RESP);
  assign bus.busy            = (state_q != IDLE);
  assign bus.rsp_id          = rsp_id_q;
  assign bus.rsp_quotient    = rsp_q_q;
  assign bus.rsp_remainder   = rsp_r_q;
  assign bus.rsp_div_by_zero = rsp_dbz_q;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Self-checking bench for div_share_ctrl (N=32, NREQ=4, MC_CYCLES=4).
// A monitor pushes the expected response for every accepted request into
// a scoreboard queue and compares on each response handshake.
module tb_div_share_ctrl;
  import div_pkg::*;

  localparam int unsigned N    = 32;
  localparam int unsigned NREQ = 4;
  localparam int unsigned MC   = 4;
  localparam int unsigned IDW  = 2;

  typedef struct {
    logic [IDW-1:0] id;
    logic [N-1:0]   q;
    logic [N-1:0]   r;
    logic           dbz;
  } exp_t;

  typedef struct {
    int unsigned id;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_share_ctrl_if #(.N(N), .NREQ(NREQ), .IDW(IDW)) bus();

  div_share_ctrl #(
    .N         (N),
    .NREQ      (NREQ),
    .MC_CYCLES (MC),
    .IDW       (IDW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  vec_t        tbl[10];
  exp_t        scb[$];
  exp_t        pend[NREQ];
  exp_t        mon_e;
  int unsigned grant_log[$];
  int          grant_edge[$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          rsp_rise_edge = 0;
  int          rsp_hs_edge = 0;
  int          ready_cnt[NREQ];
  logic        prev_rv = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [N-1:0] act, logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic exp_t model(int unsigned id, logic [N-1:0] a, logic [N-1:0] b);
    exp_t   e;
    longint sa;
    longint sd;
    sa   = longint'($signed(a));
    sd   = longint'($signed(b));
    e.id = IDW'(id);
    if (sa == 0) begin
      e.q = '0; e.r = '0; e.dbz = 1'b0;
    end else if (sd == 0) begin
      e.q = '1; e.r = '1; e.dbz = 1'b1;
    end else begin
      e.q = N'(sa / sd); e.r = N'(sa % sd); e.dbz = 1'b0;
    end
    return e;
  endfunction

  function automatic exp_t exp_of(vec_t v);
    exp_t e;
    e.id = IDW'(v.id); e.q = v.q; e.r = v.r; e.dbz = v.dbz;
    return e;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      for (int g = 0; g < NREQ; g++) begin
        if (bus.req_ready[g]) begin
          ready_cnt[g]++;
          if (bus.req_valid[g]) begin
            scb.push_back(pend[g]);
            grant_log.push_back(g);
            grant_edge.push_back(cyc + 1);
          end
        end
      end
      if (bus.req_ready != '0) chk("ready_onehot", $countones(bus.req_ready), 1);
      if (bus.rsp_valid && !prev_rv) rsp_rise_edge = cyc;
      if (bus.rsp_valid && bus.rsp_ready) begin
        rsp_hs_edge = cyc + 1;
        if (scb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got id %0d with empty scoreboard", bus.rsp_id);
        end else begin
          mon_e = scb.pop_front();
          chk("rsp_id",  N'(bus.rsp_id), N'(mon_e.id));
          chk("rsp_q",   bus.rsp_quotient, mon_e.q);
          chk("rsp_r",   bus.rsp_remainder, mon_e.r);
          chk("rsp_dbz", N'(bus.rsp_div_by_zero), N'(mon_e.dbz));
        end
      end
      prev_rv = bus.rsp_valid;
    end else begin
      prev_rv = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic raise(input int unsigned id, input logic [N-1:0] a,
                       input logic [N-1:0] b, input exp_t e);
    bus.req_dividend[id] = a;
    bus.req_divisor[id]  = b;
    pend[id]             = e;
    bus.req_valid[id]    = 1'b1;
  endtask

  task automatic raise_vec(input int unsigned i);
    raise(tbl[i].id, tbl[i].a, tbl[i].b, exp_of(tbl[i]));
  endtask

  task automatic raise_rand(input int unsigned id);
    logic [N-1:0] a;
    logic [N-1:0] b;
    a = $urandom();
    b = $urandom() >> $urandom_range(0, 31);
    if ($urandom_range(0, 1) == 1) b = -b;
    if ($urandom_range(0, 7) == 0) b = '0;
    raise(id, a, b, model(id, a, b));
  endtask

  // Waits for n acceptances; accepted requesters either drop or reload.
  task automatic wait_grants(input int n, input int budget, input bit reload);
    int got;
    int t;
    logic [NREQ-1:0] hit;
    got = 0;
    t   = 0;
    while (got < n && t < budget) begin
      @(negedge clk);
      t++;
      hit = bus.req_ready & bus.req_valid;
      got += $countones(hit);
      tick();
      for (int g = 0; g < NREQ; g++) begin
        if (hit[g]) begin
          if (reload) raise_rand(g);
          else        bus.req_valid[g] = 1'b0;
        end
      end
    end
    if (got < n) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: got %0d grants, required %0d", got, n);
    end
  endtask

  task automatic wait_idle(input int budget);
    int t;
    bit done;
    t    = 0;
    done = 1'b0;
    while (!done && t < budget) begin
      @(negedge clk);
      t++;
      if (!bus.busy && scb.size() == 0) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy=%0b pending=%0d", bus.busy, scb.size());
    end
    tick();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gl0;
    int t;

    tbl[0] = '{1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    tbl[1] = '{0, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0};
    tbl[2] = '{2, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0};
    tbl[3] = '{3, 32'd0,        32'd0,        32'd0,        32'd0,        1'b0};
    tbl[4] = '{1, 32'd5,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};
    tbl[5] = '{0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0};
    tbl[6] = '{2, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0};
    tbl[7] = '{3, 32'd0,        32'd5,        32'd0,        32'd0,        1'b0};
    tbl[8] = '{1, 32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 32'd0,        1'b0};
    tbl[9] = '{0, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};

    bus.req_valid    = '0;
    bus.req_dividend = '0;
    bus.req_divisor  = '0;
    bus.rsp_ready    = 1'b1;
    for (int g = 0; g < NREQ; g++) ready_cnt[g] = 0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", N'(bus.req_ready), 0);
    chk("rst_rsp_valid", N'(bus.rsp_valid), 0);
    chk("rst_rsp_id",    N'(bus.rsp_id), 0);
    chk("rst_rsp_q",     bus.rsp_quotient, 0);
    chk("rst_rsp_r",     bus.rsp_remainder, 0);
    chk("rst_rsp_dbz",   N'(bus.rsp_div_by_zero), 0);
    chk("rst_busy",      N'(bus.busy), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single request from requester 1: latency and one-cycle ready
    raise_vec(0);
    wait_grants(1, 20, 1'b0);
    wait_idle(30);
    chk("t1_grant_id", N'(grant_log[grant_log.size()-1]), 1);
    chk("t1_latency",  N'(rsp_rise_edge - grant_edge[grant_edge.size()-1]), MC);
    chk("t1_ready_cycles", N'(ready_cnt[1]), 1);

    // Simultaneous 0,2,3 from a zeroed pointer
    pulse_reset();
    raise_vec(1);
    raise_vec(2);
    raise_vec(3);
    gl0 = grant_log.size();
    wait_grants(3, 60, 1'b0);
    wait_idle(40);
    if (grant_log.size() >= gl0 + 3) begin
      chk("sim_order0", N'(grant_log[gl0]),   0);
      chk("sim_order1", N'(grant_log[gl0+1]), 2);
      chk("sim_order2", N'(grant_log[gl0+2]), 3);
    end

    // Remaining table vectors one at a time
    for (int i = 4; i < 10; i++) begin
      raise_vec(i);
      wait_grants(1, 20, 1'b0);
      wait_idle(30);
    end

    // Backpressure: 9/4 held in RESP while requester 2 waits
    bus.rsp_ready = 1'b0;
    raise(0, 32'd9, 32'd4, model(0, 32'd9, 32'd4));
    wait_grants(1, 20, 1'b0);
    t = 0;
    while (!bus.rsp_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("bp_reach_resp", N'(bus.rsp_valid), 1);
    tick();
    raise(2, 32'd11, 32'd3, model(2, 32'd11, 32'd3));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_rsp_valid", N'(bus.rsp_valid), 1);
      chk("bp_req_ready", N'(bus.req_ready), 0);
      chk("bp_rsp_id",    N'(bus.rsp_id), 0);
      chk("bp_rsp_q",     bus.rsp_quotient, 2);
      chk("bp_rsp_r",     bus.rsp_remainder, 1);
    end
    tick();
    bus.rsp_ready = 1'b1;
    wait_grants(1, 20, 1'b0);
    chk("bp_next_accept", N'(grant_edge[grant_edge.size()-1] - rsp_hs_edge), 1);
    chk("bp_next_id",     N'(grant_log[grant_log.size()-1]), 2);
    wait_idle(30);

    // Reset during CALC: pointer sits at 3 before the reset
    raise(2, 32'd13, 32'd5, model(2, 32'd13, 32'd5));
    wait_grants(1, 20, 1'b0);
    tick();
    tick();
    chk("mid_busy_before", N'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy",      N'(bus.busy), 0);
    chk("mid_rsp_valid", N'(bus.rsp_valid), 0);
    if (scb.size() > 0) void'(scb.pop_back());
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < MC + 2; k++) begin
      @(negedge clk);
      chk("mid_no_rsp", N'(bus.rsp_valid), 0);
    end
    tick();
    raise(0, 32'd21, 32'hFFFFFFFB, model(0, 32'd21, 32'hFFFFFFFB));
    raise(3, 32'hFFFFFFEB, 32'd4, model(3, 32'hFFFFFFEB, 32'd4));
    gl0 = grant_log.size();
    wait_grants(2, 40, 1'b0);
    wait_idle(30);
    if (grant_log.size() >= gl0 + 2) begin
      chk("mid_first_grant",  N'(grant_log[gl0]),   0);
      chk("mid_second_grant", N'(grant_log[gl0+1]), 3);
    end

    // All four continuously valid: strict rotation, MC+2 period
    for (int g = 0; g < NREQ; g++) raise_rand(g);
    gl0 = grant_log.size();
    wait_grants(12, 200, 1'b1);
    bus.req_valid = '0;
    wait_idle(30);
    if (grant_log.size() >= gl0 + 12) begin
      for (int k = 0; k < 12; k++) begin
        chk("rot_order", N'(grant_log[gl0+k]), N'(k % NREQ));
        if (k > 0) chk("rot_period", N'(grant_edge[gl0+k] - grant_edge[gl0+k-1]), MC + 2);
      end
    end

    chk("sb_drained", N'(scb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_share_ctrl.md
# div_share_ctrl

Sequencing and arbitration controller that shares one combinational signed integer divider (`integer_divider`) between `NREQ` requesters. It accepts one division at a time through per-requester valid/ready handshakes and registers the operands. It holds them stable for `MC_CYCLES` clocks so the divider can be constrained as a multicycle path, then captures quotient and remainder into a response register tagged with the requester ID. It sits between the core-side requesters and the divider datapath.

## Interface
Parameters:
- `N`, 32, operand/result width, two's complement
- `NREQ`, 4, number of requesters (≥2)
- `MC_CYCLES`, 4, cycles operands are held before result capture (≥1)
- `IDW`, `$clog2(NREQ)`, requester ID width

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  NREQ  request pending, one bit per requester
- `req_ready`  out  NREQ  request accepted this cycle (at most one bit high)
- `req_dividend`  in  NREQ×N  signed dividend per requester
- `req_divisor`  in  NREQ×N  signed divisor per requester
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  response consumer ready
- `rsp_id`  out  IDW  index of the requester the response belongs to
- `rsp_quotient`  out  N  signed quotient
- `rsp_remainder`  out  N  signed remainder
- `rsp_div_by_zero`  out  1  divisor was 0 and dividend was nonzero
- `busy`  out  1  high whenever state ≠ IDLE

## Operation
- FSM states: IDLE, CALC, RESP.
- **IDLE:**
  - The round-robin arbiter picks one asserted `req_valid`, starting at `rr_ptr`.
  - `req_ready[g]` is high combinationally for the winner only.
  - On the handshake edge: latch operands and ID, load `cnt` = `MC_CYCLES`, set `rr_ptr` = g+1 (mod NREQ), go to CALC.
  - With no request, stay in IDLE.
- **CALC:**
  - Operand registers drive the divider unchanged.
  - `cnt` decrements each edge.
  - On the edge where `cnt` == 1: capture divider outputs and the dbz flag into the rsp registers, go to RESP.
- **RESP:**
  - `rsp_valid` is high.
  - All rsp outputs are held stable until `rsp_valid` && `rsp_ready`, then go to IDLE.
  - No new request is accepted in RESP.
- **Arithmetic:**
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Dividend 0 gives q=0, r=0, dbz=0, regardless of divisor.
  - Divisor 0 with dividend ≠ 0 gives q=all-ones, r=all-ones, dbz=1.
  - 0x80000000 / −1 wraps to q=0x80000000, r=0. No flag is raised.
- `req_valid` must not depend on `req_ready`. Requesters hold operands stable while `req_valid` is high and not yet accepted.
- Dropping `req_valid` before acceptance is legal; that request is simply not served.

## Timing
- **Reset values:** state=IDLE, `rr_ptr`=0, `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_quotient`=0, `rsp_remainder`=0, `rsp_div_by_zero`=0, `busy`=0.
- **Latency:** request accepted at edge E0 gives `rsp_valid` rising at edge E0+`MC_CYCLES`.
- **Throughput:** response handshake at edge Er returns to IDLE; the earliest next acceptance is edge Er+1. The minimum period is therefore `MC_CYCLES`+2 cycles per division when `rsp_ready` is tied high.
- **Simultaneous requests:** exactly one is granted per IDLE cycle. The others keep `req_valid` high and are served in rotating order. No requester waits more than NREQ−1 grants.
- **Backpressure:** `rsp_ready` low holds RESP indefinitely, with outputs unchanged.
- **Reset mid-operation:** any state returns to IDLE immediately. The in-flight operation is discarded with no response, and `rr_ptr` returns to 0.
- Operand registers change only on an acceptance edge. This is what makes the divider legally a `MC_CYCLES` multicycle path.

## Structure
- **Package `div_pkg`:**
  - `div_state_e` enum (IDLE, CALC, RESP)
  - `DIV_N_DEFAULT` = 32
  - `DIV_MC_DEFAULT` = 4
- **Sub-module `rr_arbiter`:**
  - Parameter NREQ.
  - Inputs: request vector, pointer, enable.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational; the pointer register lives in `div_share_ctrl`.
- One `integer_divider` instance with n=`N`, fed from the operand registers.
- The dbz flag is derived from the registered operands, outside the divider.

## Test plan
- Reset, then requester 1 sends −7 / 2 with `MC_CYCLES`=4 and `rsp_ready`=1. Expect `req_ready[1]` high for one cycle, `rsp_valid` high 4 edges later, `rsp_id`=1, q=0xFFFFFFFD, r=0xFFFFFFFF, dbz=0.
- Requesters 0, 2, 3 send 7/−2, 100/7 and 0/0 simultaneously and held. Expect service order 0, 2, 3. Results: q=0xFFFFFFFD, r=1; q=14, r=2; q=0, r=0, dbz=0.
- Dividend 5, divisor 0. Expect q=0xFFFFFFFF, r=0xFFFFFFFF, dbz=1.
- Hold `rsp_ready`=0 for 10 cycles in RESP while requester 2 is valid. Expect outputs stable and `req_ready` all zero. Acceptance of requester 2 follows one cycle after `rsp_ready` rises.
- Assert `rst_n` low during CALC. Expect immediate IDLE, `busy`=0, `rsp_valid`=0, no response for that op. The next grant goes to requester 0 first.
- All four requesters valid continuously for 12 grants. Expect strict rotation 0,1,2,3,… and a period of `MC_CYCLES`+2 cycles per grant.
